// File: rtl/referee_rr_if.sv
// referee_rr_if: source-FIFO and downstream-FIFO signals of the referee.
//
// Handshake: the referee raises pop for exactly one cycle when empty is low;
// the source FIFO presents the popped word on data_in in the cycle after the
// edge that sampled pop high. The referee raises push[i] (one-hot, one
// cycle) with data_out to write channel i, and only when almost_full[i] was
// low in the cycle that decided the push. There is no backpressure on push:
// almost_full must leave enough margin for a write already in flight.
//
// Signals:
//   empty       source FIFO empty                (to referee)
//   data_in     source FIFO read data            (to referee)
//   pop         source FIFO read strobe          (from referee)
//   almost_full per-channel almost-full          (to referee)
//   push        one-hot downstream write strobe  (from referee)
//   data_out    downstream write data            (from referee)
interface referee_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
);
    logic              empty;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [NUM_CH-1:0] almost_full;
    logic [NUM_CH-1:0] push;
    logic [DATA_W-1:0] data_out;

    // master: the referee itself
    modport master (
        input  empty, data_in, almost_full,
        output pop, push, data_out
    );

    // slave: the FIFOs around the referee
    modport slave (
        output empty, data_in, almost_full,
        input  pop, push, data_out
    );
endinterface

// File: rtl/referee_rr.sv
// referee_rr: pops words from one source FIFO and dispatches each word to one
// of NUM_CH downstream FIFOs, either round-robin (skipping almost-full
// channels) or by a class field carried in the word. Words whose class names
// no existing channel are discarded and counted.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   mode        0 = round-robin, 1 = class-routed; latched only while idle
//   bus         referee_rr_if.master (empty, data_in, pop, almost_full,
//               push, data_out)
//   busy        high whenever the FSM is not idle
//   drop        one-cycle pulse when a word is discarded
//   drop_cnt    saturating count of discarded words
//   state_dbg   current FSM state (IDLE=0, FETCH=1, CAPTURE=2, DISPATCH=3)
//   rr_ptr_dbg  round-robin pointer, zero-extended to 4 bits
//
// The interface instance must be built with the same NUM_CH and DATA_W as
// this module.
module referee_rr #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 12,
    parameter int CLS_LSB = 10,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    referee_rr_if.master     bus,
    output logic             busy,
    output logic             drop,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [1:0]       state_dbg,
    output logic [3:0]       rr_ptr_dbg
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        CAPTURE  = 2'd2,
        DISPATCH = 2'd3
    } state_t;

    state_t            state;
    logic              mode_q;
    logic [CH_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] hold;
    logic [CH_W-1:0]   cls;

    // Target selection, evaluated every cycle but only acted on in DISPATCH.
    logic              tgt_found;
    logic [CH_W-1:0]   tgt_idx;
    logic              cls_bad;
    logic [CH_W:0]     scan_idx;
    logic [NUM_CH-1:0] tgt_onehot;

    always_comb begin
        tgt_found  = 1'b0;
        tgt_idx    = '0;
        cls_bad    = 1'b0;
        scan_idx   = '0;
        tgt_onehot = '0;
        if (!mode_q) begin
            // Scan from the farthest candidate back to rr_ptr so the last
            // hit written is the first free channel at or after rr_ptr.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr} + (CH_W + 1)'(k);
                if (scan_idx >= (CH_W + 1)'(NUM_CH)) begin
                    scan_idx = scan_idx - (CH_W + 1)'(NUM_CH);
                end
                if (!bus.almost_full[scan_idx[CH_W-1:0]]) begin
                    tgt_found = 1'b1;
                    tgt_idx   = scan_idx[CH_W-1:0];
                end
            end
        end else begin
            // Class routing never skips: an almost-full class channel stalls.
            if ({1'b0, cls} >= (CH_W + 1)'(NUM_CH)) begin
                cls_bad = 1'b1;
            end else if (!bus.almost_full[cls]) begin
                tgt_found = 1'b1;
                tgt_idx   = cls;
            end
        end
        if (tgt_found) begin
            tgt_onehot[tgt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode_q       <= 1'b0;
            rr_ptr       <= '0;
            hold         <= '0;
            cls          <= '0;
            bus.pop      <= 1'b0;
            bus.push     <= '0;
            bus.data_out <= '0;
            drop         <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            // pop, push and drop are single-cycle pulses.
            bus.pop  <= 1'b0;
            bus.push <= '0;
            drop     <= 1'b0;
            case (state)
                IDLE: begin
                    mode_q <= mode;
                    if (!bus.empty) begin
                        bus.pop <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    hold  <= bus.data_in;
                    cls   <= bus.data_in[CLS_LSB +: CH_W];
                    state <= DISPATCH;
                end
                DISPATCH: begin
                    // Without a target or a drop the word is simply held.
                    if (cls_bad || tgt_found) begin
                        if (cls_bad) begin
                            drop <= 1'b1;
                            if (drop_cnt != {CNT_W{1'b1}}) begin
                                drop_cnt <= drop_cnt + CNT_W'(1);
                            end
                        end else begin
                            bus.push     <= tgt_onehot;
                            bus.data_out <= hold;
                            if (!mode_q) begin
                                rr_ptr <= (tgt_idx == CH_W'(NUM_CH - 1)) ?
                                          '0 : tgt_idx + CH_W'(1);
                            end
                        end
                        if (!bus.empty) begin
                            bus.pop <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign state_dbg  = state;
    assign rr_ptr_dbg = 4'(rr_ptr);

endmodule
